sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO with on-chip storage, fill level, programmable

---
 rtl/sync_fifo_param.sv | 146 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with on-chip storage, occupancy level,
// programmable almost-full/almost-empty thresholds, sticky overflow/underflow
// error flags and a synchronous flush.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   flush           sync clear of pointers/level/rd_valid (storage untouched)
//   clr_err         sync clear of sticky overflow/underflow
//   wr_en, wr_data  write request and data
//   rd_en           read request
//   rd_data         registered read data, valid the cycle after an accepted read
//   rd_valid        rd_data holds the word popped on the previous edge
//   full, empty, almost_full, almost_empty   decoded from the level register
//   level           occupancy 0..DEPTH
//   overflow        sticky: write requested while full
//   underflow       sticky: read requested while empty
module sync_fifo_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     clr_err,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_LVL    = (AW+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q,    rd_ptr_d;
    logic [AW:0]       level_q,     level_d;
    logic [DATA_W-1:0] rd_data_q,   rd_data_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              overflow_q,  overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc,      rd_acc;

    // Flags depend only on the level register, never on this cycle's requests.
    assign full         = (level_q == DEPTH_LVL);
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= AF_LVL);
    assign almost_empty = (level_q <= AE_LVL);

    assign level     = level_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        wr_acc      = 1'b0;
        rd_acc      = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        // Clear first so that a same-cycle error set wins.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_acc = wr_en & ~full;
            rd_acc = rd_en & ~empty;

            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                rd_data_d = mem_q[rd_ptr_q];
            end
            rd_valid_d = rd_acc;

            unique case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase

            if (wr_en && full) begin
                overflow_d = 1'b1;
            end
            if (rd_en && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized and directed stimulus against a queue-based
// reference model; expected read words flow through a scoreboard queue that a
// separate monitor drains whenever the DUT presents rd_valid.
module tb_sync_fifo_param;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 8;
    localparam int unsigned AF = 6;
    localparam int unsigned AE = 2;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          clr_err;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    level;
    logic          overflow;
    logic          underflow;

    sync_fifo_param #(
        .DATA_W  (DW),
        .DEPTH   (DP),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .clr_err     (clr_err),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: FIFO contents as a plain queue plus sticky flags.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] exp_last;
    logic          m_ovf;
    logic          m_unf;

    int n_cmp;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        sb_q.delete();
        exp_last = '0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    // One clock edge: drive inputs just after the falling edge (after the
    // monitor has sampled) and advance the model to the post-edge state.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic f, input logic c);
        bit m_full;
        bit m_empty;
        @(negedge clk);
        #1;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        clr_err = c;
        m_full  = (model_q.size() == DP);
        m_empty = (model_q.size() == 0);
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (f) begin
            model_q.delete();
        end else begin
            if (r && !m_empty) sb_q.push_back(model_q.pop_front());
            if (w && !m_full)  model_q.push_back(d);
            if (w && m_full)   m_ovf = 1'b1;
            if (r && m_empty)  m_unf = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        model_reset();
        #1;
        chk("rst_level",    32'(level),        32'd0);
        chk("rst_empty",    32'(empty),        32'd1);
        chk("rst_full",     32'(full),         32'd0);
        chk("rst_af",       32'(almost_full),  32'd0);
        chk("rst_ae",       32'(almost_empty), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid),     32'd0);
        chk("rst_rd_data",  32'(rd_data),      32'd0);
        chk("rst_overflow", 32'(overflow),     32'd0);
        chk("rst_underflow",32'(underflow),    32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every falling edge compare the DUT with the model state and pop
    // the scoreboard whenever a read word is presented.
    initial begin
        forever begin
            @(negedge clk);
            chk("rd_valid", 32'(rd_valid), 32'(sb_q.size() != 0));
            if (rd_valid) begin
                if (sb_q.size() != 0) exp_last = sb_q.pop_front();
            end
            chk("rd_data",      32'(rd_data),      32'(exp_last));
            chk("level",        32'(level),        32'(model_q.size()));
            chk("full",         32'(full),         32'(model_q.size() == DP));
            chk("empty",        32'(empty),        32'(model_q.size() == 0));
            chk("almost_full",  32'(almost_full),  32'(model_q.size() >= AF));
            chk("almost_empty", 32'(almost_empty), 32'(model_q.size() <= AE));
            chk("overflow",     32'(overflow),     32'(m_ovf));
            chk("underflow",    32'(underflow),    32'(m_unf));
        end
    end

    initial begin
        logic [DW-1:0] dcnt;
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        model_reset();
        #12;
        rst_n = 1'b1;
        idle(2);

        // Fill 0x01..0x08, then a rejected 9th write.
        for (int i = 1; i <= 8; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        // Drain eight, then one read too many.
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Simultaneous read/write across pointer wrap at level 3.
        dcnt = 8'h10;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, dcnt, 1'b0, 1'b0, 1'b0);
            dcnt++;
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, dcnt, 1'b1, 1'b0, 1'b0);
            dcnt++;
        end

        // Full + wr + rd, then drain and empty + wr + rd.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, dcnt, 1'b0, 1'b0, 1'b0);
            dcnt++;
        end
        cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush at level 5 with a concurrent write; errors survive flush.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hA0 + DW'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        idle(1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        // Stale storage must not reappear after flush.
        cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Random traffic with occasional flush / clr_err and one async reset.
        for (int i = 0; i < 600; i++) begin
            logic w, r, f, c;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            f = ($urandom_range(0, 31) == 0);
            c = !f && ($urandom_range(0, 15) == 0);
            cyc(w, DW'($urandom), r, f, c);
            if (i == 300) async_reset();
        end
        idle(2);
        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
